// File: rtl/iic_write_arbiter.sv
// ---------------------------------------------------------------------------
// iic_write_arbiter
//   Round-robin arbiter and sequencer in front of a single-transaction I2C
//   write engine. One client is granted at a time. Its operands are latched
//   and the engine is launched with a one-cycle start pulse. The block then
//   waits for the engine's done pulse, or for a timeout that also pulses an
//   engine reset. A fixed bus-free gap separates consecutive transactions.
//
// Ports
//   clk_i              system clock, rising edge
//   rst_i              synchronous active-high reset
//   req_i              per-client request level, held until ack/err
//   req_slave_addr_i   7 bits per client, client i at [7i+6:7i]
//   req_pointer_i      7 bits per client, client i at [7i+6:7i]
//   req_data_i         8 bits per client, client i at [8i+7:8i]
//   grant_o            one-hot client being served
//   ack_o / err_o      one-cycle completion / timeout pulse to granted client
//   busy_o             high whenever not in IDLE
//   eng_start_o        one-cycle engine launch pulse
//   eng_slave_addr_o, eng_pointer_o, eng_data_o
//                      latched operands, stable from launch to completion
//   eng_done_i         engine completion pulse
//   eng_rst_o          one-cycle engine reset pulse after a timeout
// ---------------------------------------------------------------------------
module iic_write_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [7*NUM_REQ-1:0]   req_slave_addr_i,
  input  logic [7*NUM_REQ-1:0]   req_pointer_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [NUM_REQ-1:0]     err_o,
  output logic                   busy_o,
  output logic                   eng_start_o,
  output logic [6:0]             eng_slave_addr_o,
  output logic [6:0]             eng_pointer_o,
  output logic [7:0]             eng_data_o,
  input  logic                   eng_done_i,
  output logic                   eng_rst_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW    = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   last_q,  last_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [GW-1:0]      gap_q,   gap_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q,   ack_d;
  logic [NUM_REQ-1:0] err_q,   err_d;
  logic               busy_q,  busy_d;
  logic               start_q, start_d;
  logic               erst_q,  erst_d;
  logic [6:0]         addr_q,  addr_d;
  logic [6:0]         ptr_q,   ptr_d;
  logic [7:0]         data_q,  data_d;

  // Round-robin pick: first requester found scanning upward from last_q+1,
  // wrapping; last_q itself is examined last so a lone requester still wins.
  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_vld && req_i[(int'(last_q) + k) % NUM_REQ]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    grant_d = grant_q;
    ack_d   = '0;
    err_d   = '0;
    busy_d  = busy_q;
    start_d = 1'b0;
    erst_d  = 1'b0;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          last_d  = sel_idx;
          grant_d = NUM_REQ'(1) << sel_idx;
          addr_d  = req_slave_addr_i[7*int'(sel_idx) +: 7];
          ptr_d   = req_pointer_i[7*int'(sel_idx) +: 7];
          data_d  = req_data_i[8*int'(sel_idx) +: 8];
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // done is checked first so it wins a same-cycle timeout
        if (eng_done_i) begin
          ack_d   = grant_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = grant_q;
          erst_d  = 1'b1;
          grant_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      timer_q <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      erst_q  <= 1'b0;
      addr_q  <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      erst_q  <= erst_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  assign grant_o          = grant_q;
  assign ack_o            = ack_q;
  assign err_o            = err_q;
  assign busy_o           = busy_q;
  assign eng_start_o      = start_q;
  assign eng_rst_o        = erst_q;
  assign eng_slave_addr_o = addr_q;
  assign eng_pointer_o    = ptr_q;
  assign eng_data_o       = data_q;

endmodule

// File: tb/tb_iic_write_arbiter.sv
// Directed bench for iic_write_arbiter. Instance A uses the default timeout;
// instance B uses a 64-cycle timeout for the hang and tie scenarios.
module tb_iic_write_arbiter;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]   req_a, req_b;
  logic [7*NR-1:0] addr_v, ptr_v;
  logic [8*NR-1:0] data_v;
  logic done_a, done_b;

  logic [NR-1:0] grant_a, ack_a, err_a, grant_b, ack_b, err_b;
  logic busy_a, start_a, erst_a, busy_b, start_b, erst_b;
  logic [6:0] eaddr_a, eptr_a, eaddr_b, eptr_b;
  logic [7:0] edata_a, edata_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  iic_write_arbiter #(.NUM_REQ(NR)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a),
    .req_slave_addr_i(addr_v), .req_pointer_i(ptr_v), .req_data_i(data_v),
    .grant_o(grant_a), .ack_o(ack_a), .err_o(err_a), .busy_o(busy_a),
    .eng_start_o(start_a), .eng_slave_addr_o(eaddr_a), .eng_pointer_o(eptr_a),
    .eng_data_o(edata_a), .eng_done_i(done_a), .eng_rst_o(erst_a));

  iic_write_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(64), .GAP_CYCLES(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b),
    .req_slave_addr_i(addr_v), .req_pointer_i(ptr_v), .req_data_i(data_v),
    .grant_o(grant_b), .ack_o(ack_b), .err_o(err_b), .busy_o(busy_b),
    .eng_start_o(start_b), .eng_slave_addr_o(eaddr_b), .eng_pointer_o(eptr_b),
    .eng_data_o(edata_b), .eng_done_i(done_b), .eng_rst_o(erst_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int idx;

    rst = 1'b1; req_a = '0; req_b = '0; done_a = 1'b0; done_b = 1'b0;
    for (int i = 0; i < NR; i++) begin
      addr_v[7*i +: 7] = 7'(8'h10 + i);
      ptr_v[7*i +: 7]  = 7'(8'h20 + i);
      data_v[8*i +: 8] = 8'(8'h80 + i);
    end
    addr_v[20:14] = 7'h50; ptr_v[20:14] = 7'h12; data_v[23:16] = 8'hA5;

    // ---- reset state
    repeat (3) tick();
    chk("rst_grant", 32'(grant_a), 32'h0);
    chk("rst_busy",  32'(busy_a), 32'h0);
    chk("rst_start", 32'(start_a), 32'h0);
    chk("rst_ackerr", 32'({ack_a, err_a, erst_a}), 32'h0);
    chk("rst_ops",   32'({eaddr_a, eptr_a, edata_a}), 32'h0);
    rst = 1'b0;
    tick();

    // ---- single request, client 2, engine done 120 cycles after start
    req_a = 4'b0100;
    tick();
    chk("s_start", 32'(start_a), 32'h1);
    chk("s_grant", 32'(grant_a), 32'h4);
    chk("s_busy",  32'(busy_a), 32'h1);
    chk("s_ops",   32'({eaddr_a, eptr_a, edata_a}), 32'({7'h50, 7'h12, 8'hA5}));
    tick();
    chk("s_start_low", 32'(start_a), 32'h0);
    repeat (119) tick();
    chk("s_no_early_ack", 32'(ack_a), 32'h0);
    done_a = 1'b1;
    tick();
    done_a = 1'b0; req_a = '0;
    chk("s_ack",       32'(ack_a), 32'h4);
    chk("s_grant_clr", 32'(grant_a), 32'h0);
    chk("s_noerr",     32'({err_a, erst_a}), 32'h0);
    repeat (7) tick();
    chk("s_gap_busy", 32'(busy_a), 32'h1);
    tick();
    chk("s_idle_busy", 32'(busy_a), 32'h0);

    // ---- round robin with all four requesting
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      idx = n % NR;
      ok = 1'b0;
      for (int w = 0; w < 40; w++) begin
        tick();
        if (start_a) begin ok = 1'b1; break; end
      end
      chk("rr_start", 32'(ok), 32'h1);
      chk("rr_grant", 32'(grant_a), 32'(1 << idx));
      chk("rr_data",  32'(edata_a), 32'(data_v[8*idx +: 8]));
      repeat (5) tick();
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      chk("rr_ack", 32'(ack_a), 32'(1 << idx));
      req_a[idx] = 1'b0;
      tick();
      req_a[idx] = 1'b1;
    end
    req_a = '0;

    // ---- timeout on instance B (64 cycles)
    req_b = 4'b0001;
    tick();
    chk("to_start", 32'(start_b), 32'h1);
    chk("to_grant", 32'(grant_b), 32'h1);
    repeat (64) tick();
    chk("to_early", 32'({err_b, erst_b}), 32'h0);
    tick();
    chk("to_err",   32'(err_b), 32'h1);
    chk("to_erst",  32'(erst_b), 32'h1);
    chk("to_noack", 32'(ack_b), 32'h0);
    chk("to_gclr",  32'(grant_b), 32'h0);
    req_b = 4'b0010;
    tick();
    chk("to_pulse", 32'({err_b, erst_b}), 32'h0);
    repeat (7) tick();
    chk("to_gap_nostart", 32'(start_b), 32'h0);
    tick();
    chk("to_next_start", 32'(start_b), 32'h1);
    chk("to_next_grant", 32'(grant_b), 32'h2);
    repeat (10) tick();
    done_b = 1'b1;
    tick();
    done_b = 1'b0; req_b = '0;
    chk("to_next_ack", 32'(ack_b), 32'h2);
    chk("to_next_noerr", 32'({err_b, erst_b}), 32'h0);

    // ---- tie: done on the timeout compare cycle
    repeat (9) tick();
    chk("tie_idle", 32'(busy_b), 32'h0);
    req_b = 4'b0100;
    tick();
    chk("tie_start", 32'(start_b), 32'h1);
    repeat (64) tick();
    chk("tie_pre", 32'({ack_b, err_b}), 32'h0);
    done_b = 1'b1;
    tick();
    done_b = 1'b0; req_b = '0;
    chk("tie_ack",  32'(ack_b), 32'h4);
    chk("tie_noerr", 32'({err_b, erst_b}), 32'h0);

    // ---- operand stability and request drop on A
    repeat (10) tick();
    chk("op_idle", 32'(busy_a), 32'h0);
    data_v[15:8] = 8'h3C;
    req_a = 4'b0010;
    tick();
    chk("op_grant", 32'(grant_a), 32'h2);
    chk("op_data",  32'(edata_a), 32'h3C);
    data_v[15:8] = 8'hC3;
    req_a = '0;
    repeat (5) tick();
    chk("op_hold_data",  32'(edata_a), 32'h3C);
    chk("op_hold_grant", 32'(grant_a), 32'h2);
    repeat (15) tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    chk("op_ack", 32'(ack_a), 32'h2);
    tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    chk("op_stray0", 32'(ack_a), 32'h0);
    tick();
    chk("op_stray1", 32'(ack_a), 32'h0);

    // ---- synchronous reset mid-WAIT_DONE
    repeat (10) tick();
    req_a = 4'b0100;
    tick();
    chk("rs_grant", 32'(grant_a), 32'h4);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rs_outs", 32'({grant_a, ack_a, err_a, busy_a, start_a, erst_a}), 32'h0);
    chk("rs_ops",  32'({eaddr_a, eptr_a, edata_a}), 32'h0);
    rst = 1'b0;
    req_a = 4'b0101;
    tick();
    chk("rs_win0",  32'(grant_a), 32'h1);
    chk("rs_start", 32'(start_a), 32'h1);
    repeat (4) tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0; req_a = '0;
    chk("rs_ack", 32'(ack_a), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
